// File: rtl/half_mult_arbiter.sv
// Round-robin arbiter that shares one FP16 multiplier among NUM_REQ requesters; 2-cycle request-to-result latency.
// Backpressure: a held result (resp_ready=0) closes the accept window, so req_ready stays 0 until it drains.
module half_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*16-1:0] req_op1,
    input  logic [NUM_REQ*16-1:0] req_op2,
    output logic [15:0]           mult_float1,
    output logic [15:0]           mult_float2,
    input  logic [15:0]           mult_product,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [15:0]           resp_product,
    output logic [CNT_W-1:0]      issue_count,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr, id_r, grant_idx;
    logic [15:0]     op1_r, op2_r, op1_sel, op2_sel;
    logic            grant_vld, accept, handshake;
    logic [ID_W:0]   cand;

    // Search starts at rr_ptr and wraps at NUM_REQ, so out-of-range indices never appear.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_X) begin
                cand = cand - NUM_REQ_X;
            end
            if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        op1_sel = '0;
        op2_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                op1_sel = req_op1[16*i +: 16];
                op2_sel = req_op2[16*i +: 16];
            end
        end
    end

    always_comb begin
        accept    = (state == IDLE) || ((state == RESP) && resp_ready);
        handshake = accept && grant_vld;
        req_ready = '0;
        if (handshake) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
        end
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = handshake ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            op1_r        <= '0;
            op2_r        <= '0;
            id_r         <= '0;
            resp_product <= '0;
            resp_id      <= '0;
            issue_count  <= '0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                op1_r       <= op1_sel;
                op2_r       <= op2_sel;
                id_r        <= grant_idx;
                rr_ptr      <= (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
                issue_count <= issue_count + CNT_W'(1);
            end
            if (state == CALC) begin
                resp_product <= mult_product;
                resp_id      <= id_r;
            end
        end
    end

    assign mult_float1 = op1_r;
    assign mult_float2 = op2_r;
    assign resp_valid  = (state == RESP);
    assign busy        = (state != IDLE);
endmodule
